// File: rtl/sel_debounce_pkg.sv
// rtl/sel_debounce_pkg.sv - shared FSM states and pattern codes for the select debouncer and display
package sel_pkg;

  // Debouncer FSM states
  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_STABLE = 2'd1,
    S_PEND   = 2'd2
  } sel_state_t;

  // Stable-count register width; covers STABLE_N up to 15
  localparam int SEL_CNT_W = 4;

  // All-ones code, reserved when the hold feature is built in
  localparam logic [1:0] SEL_RESERVED = 2'b11;

  // Pattern codes understood by the display stage
  localparam logic [1:0] SEL_P0 = 2'b00;
  localparam logic [1:0] SEL_P1 = 2'b01;
  localparam logic [1:0] SEL_P2 = 2'b10;

endpackage

// File: rtl/sel_debounce_if.sv
// rtl/sel_debounce_if.sv - switch input and committed select outputs of the debouncer
interface sel_debounce_if #(
  parameter int SEL_W = 2
);
  logic [SEL_W-1:0] sw_raw;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             sel_chg;
  logic             tick;

  // Environment side: drives the switches, observes the code
  modport master (
    output sw_raw,
    input  sel,
    input  sel_valid,
    input  sel_chg,
    input  tick
  );

  // Debouncer side
  modport slave (
    input  sw_raw,
    output sel,
    output sel_valid,
    output sel_chg,
    output tick
  );
endinterface

// File: rtl/sel_debounce_tick_gen.sv
// rtl/sel_debounce_tick_gen.sv - free-running prescaler with a registered one-cycle sample strobe
module tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [DIV_W-1:0] cnt;

  // Count every clock; strobe is high for the cycle after the counter wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      tick <= &cnt;
    end
  end

endmodule

// File: rtl/sel_debounce.sv
// rtl/sel_debounce.sv - synchronise and debounce the slide switches into a committed select code (option: SEL_INV_HOLD_EN)
module sel_debounce
  import sel_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int STABLE_N = 4,
  parameter int SEL_W    = 2
) (
  input  logic          clk,
  input  logic          rst,
  sel_debounce_if.slave bus
);

  localparam logic [SEL_CNT_W-1:0] CNT_LIM = SEL_CNT_W'(STABLE_N);

  logic                 tick;
  logic [SEL_W-1:0]     s1, s2;
  logic [SEL_W-1:0]     cand, cand_nxt;
  logic [SEL_CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0]     sel_q;
  logic                 sel_valid_q;
  logic                 sel_chg_q;
  logic                 commit;
  logic                 rsv;
  sel_state_t           state, state_nxt;

  tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef SEL_INV_HOLD_EN
  localparam logic [SEL_W-1:0] RSV_CODE = {SEL_W{1'b1}};
  assign rsv = (s2 == RSV_CODE);
`else
  assign rsv = 1'b0;
`endif

  // Two-flop synchroniser on the raw switch levels
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.sw_raw;
      s2 <= s1;
    end
  end

  // Candidate tracking: a new sample restarts the run, a repeat extends it up to the limit
  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = cnt;
    if (s2 != cand) begin
      cand_nxt = s2;
      cnt_nxt  = SEL_CNT_W'(1);
    end else if (cnt >= CNT_LIM) begin
      cnt_nxt = CNT_LIM;
    end else begin
      cnt_nxt = cnt + SEL_CNT_W'(1);
    end
  end

  // Candidate and count only move on sample ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= SEL_W'(SEL_P0);
      cnt  <= '0;
    end else if (tick) begin
      cand <= cand_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Next-state and commit decision, evaluated only on sample ticks
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    if (tick) begin
      case (state)
        S_WAIT: begin
          if (!rsv && cnt_nxt >= CNT_LIM) begin
            commit    = 1'b1;
            state_nxt = S_STABLE;
          end
        end
        S_STABLE: begin
          if (!rsv && s2 != sel_q) begin
            // With a one-sample threshold the first differing tick commits directly
            if (cnt_nxt >= CNT_LIM) commit = 1'b1;
            else                    state_nxt = S_PEND;
          end
        end
        S_PEND: begin
          if (s2 == sel_q) begin
            state_nxt = S_STABLE;
          end else if (rsv) begin
            state_nxt = sel_valid_q ? S_STABLE : S_WAIT;
          end else if (cnt_nxt >= CNT_LIM) begin
            commit    = 1'b1;
            state_nxt = S_STABLE;
          end
        end
        default: state_nxt = S_WAIT;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  // Committed code, valid flag and the one-cycle change pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= SEL_W'(SEL_P0);
      sel_valid_q <= 1'b0;
      sel_chg_q   <= 1'b0;
    end else begin
      sel_chg_q <= 1'b0;
      if (commit) begin
        sel_q       <= cand_nxt;
        sel_valid_q <= 1'b1;
        sel_chg_q   <= (cand_nxt != sel_q);
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.sel_chg   = sel_chg_q;
  assign bus.tick      = tick;

endmodule

// File: tb/tb_sel_debounce.sv
// tb/tb_sel_debounce.sv - self-checking bench for sel_debounce (DIV_W=2, STABLE_N=3)
module tb_sel_debounce;
  import sel_pkg::*;

  localparam int N   = 3;
  localparam int DIV = 4;
`ifdef SEL_INV_HOLD_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  typedef struct {
    logic [1:0] sw;
    int         hold;
    logic [1:0] e_sel;
    logic       e_valid;
    int         e_pulses;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sel_debounce_if #(.SEL_W(2)) bus ();

  sel_debounce #(
    .DIV_W    (2),
    .STABLE_N (N),
    .SEL_W    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: switches reach the sampler 2 clocks late, a sample is taken every
  // DIV clocks after reset, and a code commits once the last N samples all equal it.
  logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00, m_sel = 2'b00;
  logic       m_valid = 1'b0, m_chg = 1'b0, m_tick = 1'b0;
  int         m_cyc = 0;
  logic [1:0] m_hist[$];

  always @(posedge clk) begin
    bit chg_n;
    int run;
    chg_n = 1'b0;
    if (rst) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_sel = 2'b00;
      m_valid = 1'b0; m_tick = 1'b0; m_cyc = 0;
      m_hist.delete();
    end else begin
      if (m_tick) begin
        m_hist.push_back(m_s2);
        if (m_hist.size() > N) void'(m_hist.pop_front());
        run = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
          if (m_hist[i] != m_s2) break;
          run++;
        end
        if (run >= N && !(FEAT && m_s2 == SEL_RESERVED) && (!m_valid || m_s2 != m_sel)) begin
          chg_n   = (m_s2 != m_sel);
          m_sel   = m_s2;
          m_valid = 1'b1;
        end
      end
      m_cyc++;
      m_tick = (m_cyc % DIV == 0);
      m_s2 = m_s1;
      m_s1 = bus.sw_raw;
    end
    m_chg = chg_n;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sel",   bus.sel,       m_sel);
      check("model_valid", bus.sel_valid, m_valid);
      check("model_chg",   bus.sel_chg,   m_chg);
      check("model_tick",  bus.tick,      m_tick);
    end
  end

  int tb_cyc     = 0;
  int pulse_cnt  = 0;
  int last_pulse = 0;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tb_cyc++;
      if (bus.sel_chg === 1'b1) begin
        pulse_cnt++;
        last_pulse = tb_cyc;
      end
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 4 * DIV; i++) begin
      step(1);
      if (bus.tick === 1'b1) return;
    end
    check("wait_tick_timeout", 32'd0, 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    int c0, t1;
    vecs[0] = '{SEL_P0, 20, SEL_P0, 1'b1, 1};
    vecs[1] = '{SEL_P0, 20, SEL_P0, 1'b1, 0};
    vecs[2] = '{SEL_P1, 20, SEL_P1, 1'b1, 1};
    vecs[3] = '{2'b11,  20, FEAT ? SEL_P1 : 2'b11, 1'b1, FEAT ? 0 : 1};
    vecs[4] = '{SEL_P2, 20, SEL_P2, 1'b1, 1};
    vecs[5] = '{SEL_P1, 6,  SEL_P2, 1'b1, 0};
    vecs[6] = '{SEL_P2, 20, SEL_P2, 1'b1, 0};

    // Reset held with a live switch value
    bus.sw_raw = 2'b01;
    rst = 1'b1;
    step(3);
    check("rst_sel",   bus.sel,       2'b00);
    check("rst_valid", bus.sel_valid, 1'b0);
    check("rst_chg",   bus.sel_chg,   1'b0);
    check("rst_tick",  bus.tick,      1'b0);

    // First commit, tick spacing after release
    rst = 1'b0;
    bus.sw_raw = 2'b10;
    c0 = tb_cyc;
    pulse_cnt = 0;
    wait_tick();
    check("first_tick_delay", tb_cyc - c0, 4);
    t1 = tb_cyc;
    wait_tick();
    check("tick_period", tb_cyc - t1, 4);
    step(20 - (tb_cyc - c0));
    check("first_pulses", pulse_cnt, 1);
    check("first_pulse_cycle", last_pulse - c0, 13);
    check("first_sel", bus.sel, 2'b10);
    check("first_valid", bus.sel_valid, 1'b1);

    // Glitch shorter than the stable window is rejected
    pulse_cnt = 0;
    bus.sw_raw = 2'b01;
    step(6);
    bus.sw_raw = 2'b10;
    step(20);
    check("glitch_pulses", pulse_cnt, 0);
    check("glitch_sel", bus.sel, 2'b10);

    // Bounce restarts the count; commit lands 3 ticks after the last toggle
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      wait_tick();
      bus.sw_raw = (i % 2 == 0) ? 2'b01 : 2'b00;
    end
    c0 = tb_cyc;
    check("bounce_no_early", pulse_cnt, 0);
    step(16);
    check("bounce_pulses", pulse_cnt, 1);
    check("bounce_pulse_cycle", last_pulse - c0, 13);
    check("bounce_sel", bus.sel, 2'b00);

    // Reserved all-ones code from sel=01
    bus.sw_raw = 2'b01;
    step(20);
    check("pre_rsv_sel", bus.sel, 2'b01);
    pulse_cnt = 0;
    bus.sw_raw = 2'b11;
    step(20 * DIV);
    check("rsv_sel", bus.sel, FEAT ? 2'b01 : 2'b11);
    check("rsv_pulses", pulse_cnt, FEAT ? 1'b0 : 1'b1);

    // Reset while pending with two matching samples counted
    wait_tick();
    bus.sw_raw = 2'b10;
    wait_tick();
    wait_tick();
    step(1);
    rst = 1'b1;
    step(2);
    check("midrst_sel",   bus.sel,       2'b00);
    check("midrst_valid", bus.sel_valid, 1'b0);
    check("midrst_chg",   bus.sel_chg,   1'b0);
    check("midrst_tick",  bus.tick,      1'b0);
    rst = 1'b0;
    c0 = tb_cyc;
    pulse_cnt = 0;
    step(16);
    check("midrst_pulses", pulse_cnt, 1);
    check("midrst_pulse_cycle", last_pulse - c0, 13);
    check("midrst_sel_after", bus.sel, 2'b10);

    // Table of hold-and-check vectors
    for (int v = 0; v < 7; v++) begin
      pulse_cnt = 0;
      bus.sw_raw = vecs[v].sw;
      step(vecs[v].hold);
      check($sformatf("vec%0d_sel", v),    bus.sel,       vecs[v].e_sel);
      check($sformatf("vec%0d_valid", v),  bus.sel_valid, vecs[v].e_valid);
      check($sformatf("vec%0d_pulses", v), pulse_cnt,     vecs[v].e_pulses);
    end

    // Random switch activity with occasional resets, checked against the model
    for (int r = 0; r < 300; r++) begin
      bus.sw_raw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step($urandom_range(1, 14));
    end

    chk_en = 1'b0;
    step(1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sel_debounce.md
Name: sel_debounce

Overview:
- Upstream stage for the seven-segment pattern display; it produces the 2-bit pattern-select code that the display consumes.
- Synchronises and debounces the raw slide-switch pair, then commits a new code only after it has been stable for STABLE_N sample ticks.
- Runs on the board clock, sampling on an internal clock-enable tick rather than a divided clock.
- Outputs a registered code, a valid flag and a one-cycle change pulse.

Parameters:
- DIV_W, 16, prescaler width; one sample tick every 2^DIV_W clocks.
- STABLE_N, 4, number of consecutive equal samples required to commit (range 1..15).
- SEL_W, 2, width of the switch/select code.

Ports:
- clk  input  1  board clock
- rst  input  1  reset; synchronous, active-high
- sw_raw  input  SEL_W  asynchronous raw switch levels
- sel  output  SEL_W  committed select code
- sel_valid  output  1  high once any code has been committed
- sel_chg  output  1  one-cycle pulse when sel takes a new value
- tick  output  1  one-cycle sample strobe, exported for downstream blink counters

Behaviour:
- Reset (rst high at a clk edge): all outputs clear, i.e. sel=0, sel_valid=0, sel_chg=0, tick=0. Prescaler, candidate, stable counter and synchroniser flops also clear, and the FSM returns to S_WAIT. Reset mid-debounce discards the pending candidate.
- Synchroniser: two flops on sw_raw. s2 is the synchronised value, 2 clocks of latency.
- Prescaler: a DIV_W-bit up-counter wraps 2^DIV_W-1 -> 0. tick is registered high for the single cycle after the counter wraps, giving exactly one tick per 2^DIV_W clocks.
- All FSM and counter updates occur only in cycles where tick=1. In other cycles state holds, and sel_chg is 0 except on the commit cycle.
- Candidate logic, on a tick:
  - if s2 != cand: cand <= s2, cnt <= 1
  - else: cnt <= cnt+1, saturating at STABLE_N
- FSM:
  - S_WAIT (nothing committed): when cnt reaches STABLE_N -> commit cand, go to S_STABLE.
  - S_STABLE: on a tick with s2 != sel -> S_PEND (cand reloads, cnt=1).
  - S_PEND:
    - s2 returns to sel before reaching STABLE_N -> S_STABLE with no commit (glitch rejected).
    - cand stable for STABLE_N ticks -> commit, go to S_STABLE.
- Commit: sel <= cand, sel_valid <= 1, sel_chg = 1 for exactly the cycle following the committing tick. No pulse if cand == sel.
- STABLE_N=1: commit on the first tick that sees a new value.
- Latency from a clean switch edge: 2 clocks for synchronisation, plus up to 2^DIV_W clocks waiting for the first tick, plus (STABLE_N-1) further ticks.
- A bounce that changes cand restarts the count. Alternating values never commit.
- sel is glitch-free and changes at most once per tick.

Optional Feature:
- Macro SEL_INV_HOLD_EN.
- Defined: code all-ones (2'b11 for SEL_W=2) is treated as reserved.
  - It is never committed. In S_STABLE or S_WAIT it does not start a pending count, and sel holds its last value.
  - In S_PEND, a reserved sample returns the FSM to S_STABLE if a code is already committed, otherwise to S_WAIT.
- Undefined: all-ones is an ordinary code and is debounced and committed like any other.

Decomposition:
- Shared package sel_pkg contains:
  - FSM state enum (S_WAIT, S_STABLE, S_PEND)
  - SEL_RESERVED constant (all-ones)
  - the named pattern codes SEL_P0=2'b00, SEL_P1=2'b01, SEL_P2=2'b10 used by the display stage
- One natural sub-module, tick_gen (prescaler plus registered strobe, parameter DIV_W). It is reusable by the display's blink counter in place of a derived clock.

Test Plan (bench params DIV_W=2, so a tick every 4 clocks; STABLE_N=3):
- Reset: hold rst high for 3 cycles with sw_raw=2'b01 -> sel=0, sel_valid=0, sel_chg=0, tick=0. After release, the first tick is 4 clocks later and ticks repeat every 4 clocks.
- First commit: sw_raw=2'b10 held steady after reset -> sel=2'b10 and sel_valid=1 with a single sel_chg pulse on the 3rd tick after s2 shows 2'b10. No pulse before that.
- Glitch rejection: from sel=2'b10, drive sw_raw=2'b01 for 6 clocks then back to 2'b10 -> sel stays 2'b10 and sel_chg never asserts.
- Bounce restart: toggle sw_raw 01/00 on alternate ticks for 10 ticks, then hold 2'b00 -> commit happens exactly 3 ticks after the last toggle, with one sel_chg pulse.
- Reserved code: with SEL_INV_HOLD_EN defined, hold sw_raw=2'b11 for 20 ticks from sel=2'b01 -> sel stays 2'b01 and no pulse. With the macro undefined -> sel=2'b11 after 3 ticks.
- Reset mid-operation: assert rst during S_PEND with cnt=2 -> all outputs 0. The next commit needs a full 3 ticks after release.
